// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-direction phase scheduler with min/max green, yellow, all-red and preemption.
// Define NIGHT_FLASH_EN to add the i_night input and the flashing-yellow FLASH state.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_ALL_CLR  | both red, clearance; then green of next_dir / hold / flash
// ST_H_GREEN  | H green + walk, V red
// ST_H_YELLOW | H yellow, V red
// ST_V_GREEN  | V green + walk, H red
// ST_V_YELLOW | V yellow, H red
// ST_PRE_HOLD | both red while preempt is held
// ST_FLASH    | night mode, both yellows blinking (NIGHT_FLASH_EN only)
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 40,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_h_req,
    input  logic       i_v_req,
    input  logic       i_h_ped,
    input  logic       i_v_ped,
    input  logic       i_preempt,
`ifdef NIGHT_FLASH_EN
    input  logic       i_night,
`endif
    output logic       o_hr,
    output logic       o_hy,
    output logic       o_hg,
    output logic       o_vr,
    output logic       o_vy,
    output logic       o_vg,
    output logic       o_h_walk,
    output logic       o_v_walk,
    output logic [7:0] o_count
);

    localparam logic [7:0] C_MIN = 8'(MIN_GREEN - 1);
    localparam logic [7:0] C_MAX = 8'(MAX_GREEN - 1);
    localparam logic [7:0] C_YEL = 8'(YELLOW - 1);
    localparam logic [7:0] C_AR  = 8'(ALL_RED - 1);

    typedef enum logic [2:0] {
        ST_ALL_CLR,
        ST_H_GREEN,
        ST_H_YELLOW,
        ST_V_GREEN,
        ST_V_YELLOW,
        ST_PRE_HOLD
`ifdef NIGHT_FLASH_EN
        , ST_FLASH
`endif
    } state_t;

    state_t     r_state, w_state_nx;
    logic [7:0] r_count, w_count_nx;
    logic [7:0] r_elapsed, w_elapsed_nx;
    logic       r_rested, w_rested_nx;
    logic       r_dir_v, w_dir_v_nx;
    logic       r_flash, w_flash_nx;
    logic       r_h_ped, r_v_ped;
    logic       w_pend, w_own_req, w_green_exit, w_night;
    logic       w_enter_h, w_enter_v;
    logic       w_hr, w_hy, w_hg, w_vr, w_vy, w_vg, w_hw, w_vw;

`ifdef NIGHT_FLASH_EN
    assign w_night = i_night;
`else
    assign w_night = 1'b0;
`endif

    // Demand from the opposite direction; only meaningful while a green is active.
    assign w_pend       = (r_state == ST_H_GREEN) ? (i_v_req | r_v_ped) : (i_h_req | r_h_ped);
    assign w_own_req    = (r_state == ST_H_GREEN) ? i_h_req : i_v_req;
    assign w_green_exit = i_preempt |
                          (w_pend & (r_rested | (r_count == 8'd0) |
                                     ((r_elapsed == C_MIN) & ~w_own_req)));

    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count - 8'd1;
        w_elapsed_nx = r_elapsed;
        w_rested_nx  = r_rested;
        w_dir_v_nx   = r_dir_v;
        w_flash_nx   = 1'b0;
        case (r_state)
            ST_ALL_CLR: begin
                if (r_count == 8'd0) begin
                    if (i_preempt) begin
                        w_state_nx = ST_PRE_HOLD;
                        w_count_nx = 8'd0;
                    end
`ifdef NIGHT_FLASH_EN
                    else if (w_night) begin
                        w_state_nx = ST_FLASH;
                        w_count_nx = 8'd0;
                        w_flash_nx = 1'b1;
                    end
`endif
                    else begin
                        w_state_nx   = r_dir_v ? ST_V_GREEN : ST_H_GREEN;
                        w_count_nx   = C_MAX;
                        w_elapsed_nx = 8'd0;
                        w_rested_nx  = 1'b0;
                    end
                end
            end
            ST_H_GREEN, ST_V_GREEN: begin
                if (w_green_exit) begin
                    w_state_nx = (r_state == ST_H_GREEN) ? ST_H_YELLOW : ST_V_YELLOW;
                    w_count_nx = C_YEL;
                end else if (r_count == 8'd0) begin
                    // No opposing demand at max green: rest, and let any later demand exit at once.
                    w_count_nx   = C_MAX;
                    w_elapsed_nx = C_MIN;
                    w_rested_nx  = 1'b1;
                end else if (r_elapsed != C_MIN) begin
                    w_elapsed_nx = r_elapsed + 8'd1;
                end
            end
            ST_H_YELLOW, ST_V_YELLOW: begin
                if (r_count == 8'd0) begin
                    w_state_nx = ST_ALL_CLR;
                    w_count_nx = C_AR;
                    w_dir_v_nx = (r_state == ST_H_YELLOW);
                end
            end
            ST_PRE_HOLD: begin
                w_count_nx = 8'd0;
                if (!i_preempt) begin
                    w_state_nx = ST_ALL_CLR;
                    w_count_nx = C_AR;
                end
            end
`ifdef NIGHT_FLASH_EN
            ST_FLASH: begin
                w_count_nx = 8'd0;
                if (i_preempt) begin
                    w_state_nx = ST_PRE_HOLD;
                end else if (!w_night) begin
                    w_state_nx = ST_ALL_CLR;
                    w_count_nx = C_AR;
                end else begin
                    w_flash_nx = ~r_flash;
                end
            end
`endif
            default: begin
                w_state_nx = ST_ALL_CLR;
                w_count_nx = C_AR;
            end
        endcase
    end

    assign w_enter_h = (r_state == ST_ALL_CLR) && (w_state_nx == ST_H_GREEN);
    assign w_enter_v = (r_state == ST_ALL_CLR) && (w_state_nx == ST_V_GREEN);

    // Lamps are decoded from the next state so that they register together with it.
    always_comb begin
        w_hr = 1'b0; w_hy = 1'b0; w_hg = 1'b0;
        w_vr = 1'b0; w_vy = 1'b0; w_vg = 1'b0;
        w_hw = 1'b0; w_vw = 1'b0;
        case (w_state_nx)
            ST_H_GREEN:  begin w_hg = 1'b1; w_vr = 1'b1; w_hw = 1'b1; end
            ST_H_YELLOW: begin w_hy = 1'b1; w_vr = 1'b1; end
            ST_V_GREEN:  begin w_hr = 1'b1; w_vg = 1'b1; w_vw = 1'b1; end
            ST_V_YELLOW: begin w_hr = 1'b1; w_vy = 1'b1; end
`ifdef NIGHT_FLASH_EN
            ST_FLASH:    begin w_hy = w_flash_nx; w_vy = w_flash_nx; end
`endif
            default:     begin w_hr = 1'b1; w_vr = 1'b1; end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_ALL_CLR;
            r_count   <= C_AR;
            r_elapsed <= 8'd0;
            r_rested  <= 1'b0;
            r_dir_v   <= 1'b0;
            r_flash   <= 1'b0;
            r_h_ped   <= 1'b0;
            r_v_ped   <= 1'b0;
            o_hr <= 1'b1; o_hy <= 1'b0; o_hg <= 1'b0;
            o_vr <= 1'b1; o_vy <= 1'b0; o_vg <= 1'b0;
            o_h_walk <= 1'b0; o_v_walk <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_elapsed <= w_elapsed_nx;
            r_rested  <= w_rested_nx;
            r_dir_v   <= w_dir_v_nx;
            r_flash   <= w_flash_nx;
            r_h_ped   <= (r_h_ped | i_h_ped) & ~w_enter_h;
            r_v_ped   <= (r_v_ped | i_v_ped) & ~w_enter_v;
            o_hr <= w_hr; o_hy <= w_hy; o_hg <= w_hg;
            o_vr <= w_vr; o_vy <= w_vy; o_vg <= w_vg;
            o_h_walk <= w_hw; o_v_walk <= w_vw;
        end
    end

    assign o_count = r_count;

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven phase scheduler for a two-direction crossing (horizontal H / vertical V).
- Arbitrates vehicle-sensor and pedestrian requests between directions, and enforces minimum green, maximum green, yellow and all-red clearance times.
- Provides emergency preemption.
- Drives the six lamp outputs plus a per-phase countdown, the same lamp/countdown interface as the fixed-cycle light controller it supersedes. One clk cycle equals one second.

Parameters:
- MIN_GREEN, 10, minimum green duration in cycles (>=2).
- MAX_GREEN, 40, maximum green duration before forced handover (>MIN_GREEN, <=255).
- YELLOW, 3, yellow duration in cycles (>=1).
- ALL_RED, 2, all-red clearance duration in cycles (>=1).

Ports:
- clk  input  1  system clock, 1 Hz tick.
- rst  input  1  asynchronous active-high reset.
- h_req  input  1  H vehicle sensor, level.
- v_req  input  1  V vehicle sensor, level.
- h_ped  input  1  H pedestrian button, single-cycle pulse, latched internally.
- v_ped  input  1  V pedestrian button, single-cycle pulse, latched internally.
- preempt  input  1  emergency preemption, level.
- hr, hy, hg  output  1 each  H red/yellow/green lamps.
- vr, vy, vg  output  1 each  V red/yellow/green lamps.
- h_walk, v_walk  output  1 each  walk indication.
- count  output  8  seconds remaining in current phase.

Behaviour:
- Reset (async, rst=1): state H_CLEAR-equivalent ALL_CLR with next_dir=H; hr=vr=1, all other lamps 0; h_walk=v_walk=0; count=ALL_RED-1; pedestrian latches cleared.
- All outputs registered.
- Exactly one lamp per direction is lit in every non-preempt state.
- States: ALL_CLR, H_GREEN, H_YELLOW, V_GREEN, V_YELLOW, PRE_HOLD.
- Entering a phase loads count with (duration-1). count decrements by 1 each cycle and leaves the phase on the cycle after count==0.
- ALL_CLR:
  - both red.
  - At count==0: go to next_dir green, or PRE_HOLD if preempt=1.
- X_GREEN (X = H or V; Y = the opposite direction):
  - count loaded MAX_GREEN-1.
  - Internal elapsed counter starts at 0 on entry.
  - x_walk=1 throughout.
  - X pedestrian latch cleared on entry.
  - "Y pending" = y_req OR Y pedestrian latch.
  - Early exit to X_YELLOW when elapsed==MIN_GREEN-1, Y pending, and x_req=0.
  - Max exit to X_YELLOW when count==0 and Y pending.
  - When count==0 and Y is not pending: rest in green, reloading count=MAX_GREEN-1 and elapsed=MIN_GREEN-1. Thereafter any Y demand exits on the next cycle.
- X_YELLOW:
  - count YELLOW-1 down to 0.
  - Then ALL_CLR with next_dir=Y.
- Pedestrian latches:
  - set on pulse.
  - A set and a clear in the same cycle resolve to set only if the pulse belongs to the direction not currently entering green.
- Preempt:
  - preempt=1 in X_GREEN forces X_YELLOW next cycle, ignoring MIN_GREEN.
  - In yellow or ALL_CLR, the phase completes normally, then PRE_HOLD.
  - PRE_HOLD: both red, count=0, walks 0. Held while preempt=1.
  - On preempt=0: ALL_CLR (count=ALL_RED-1), then the green of next_dir, which is the direction opposite the last green.
- Simultaneous H and V demand on entry of ALL_CLR: next_dir alternation guarantees round-robin; no starvation.
- rst asserted mid-phase returns immediately to the reset state.

Optional Feature:
- Macro NIGHT_FLASH_EN.
- When defined:
  - Adds input night (1 bit).
  - night=1 sampled in ALL_CLR at count==0 enters FLASH: all red/green off, walks off, count=0, hy=vy toggling each cycle starting at 1.
  - night=0 leaves FLASH to ALL_CLR.
  - preempt overrides FLASH, going to PRE_HOLD.
- When undefined: no night port, no FLASH state; behaviour exactly as above.

Test Plan:
- Reset release, no demand -> cycles 0-1 hr=vr=1 count=1,0; cycle 2 hg=1 h_walk=1 count=39; rests in H green, count reloads 39 after 0.
- v_req=1 constant, h_req=0 from reset -> H green 10 cycles (count 39..30), hy count 2,1,0, all-red 1,0, then vg=1 count=39.
- h_req=1 and v_req=1 constant -> H green full 40 cycles (count to 0), yellow 3, all-red 2, V green 40; strict alternation over 3 cycles.
- Single v_ped pulse during H green with v_req=0, h_req=0 -> exit at elapsed 9; V green entered with v_walk=1; V latch cleared; no second V service without new demand.
- preempt=1 at H green count=35 -> next cycle hy=1 count=2; yellow, all-red, PRE_HOLD hr=vr=1 count=0; preempt=0 -> all-red count 1,0, then vg=1.
- NIGHT_FLASH_EN: night=1 in all-red -> hy=vy toggling 1,0,1 with hr=vr=0; night=0 -> all-red count=1, then normal green.
